jtag_axi_bridge: RTL and testbench
==================================

# jtag_axi_bridge

Converts the JTAG debug module's single-outstanding memory request (valid/we/addr/wdata/sel) into a protocol-compliant AXI4-Lite master transaction and returns a one-cycle response with read data and error status. It sits between the debug module's memory port and the system AXI4-Lite interconnect. It replaces direct wiring of the request valid onto AW/W/AR with proper per-channel handshakes.

## Interface
Parameters:
- ADDR_W, 32, address width of request and AXI address channels
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  memory request from debug module
- req_ready_o  out  1  bridge idle, request accepted this cycle if req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  byte address, passed unmodified
- req_wdata_i  in  DATA_W  write data
- req_sel_i  in  DATA_W/8  byte strobes
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  DATA_W  read data, held until next completion
- resp_err_o  out  1  1 if xRESP was SLVERR/DECERR, held with resp_rdata_o
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, widths per ADDR_W/DATA_W, prot fixed 3'b000

## Operation
- States: IDLE, WADDR (AW and/or W outstanding), WRESP, RADDR, RDATA, DONE.
- IDLE: req_ready_o=1. On req_valid_i: register addr, wdata, sel, we; go WADDR if we else RADDR. No other state accepts requests.
- WADDR: awvalid and wvalid both asserted on entry; each drops independently the cycle after its own handshake (valid&ready sampled high). Completion of both (same cycle or different cycles, either order) moves to WRESP. Valids never drop before handshake; addr/data/strb stable while valid.
- WRESP: bready=1. On bvalid: capture err=bresp[1], rdata register cleared to 0, go DONE.
- RADDR: arvalid=1 until arready; then RDATA.
- RDATA: rready=1. On rvalid: capture rdata, err=rresp[1], go DONE.
- DONE: resp_valid_o=1 for exactly one cycle, then IDLE.
- bready/rready asserted only in WRESP/RDATA; B or R valid in other states is ignored (not consumed).
- No timeout; a non-responding slave stalls the bridge indefinitely.
- Reset values: req_ready_o=0 during reset, 1 after release (IDLE); all AXI valids/readies 0; resp_valid_o=0; resp_rdata_o=0; resp_err_o=0; state IDLE.
- Reset mid-transaction: all outputs immediately return to reset values; in-flight AXI transaction is abandoned (system-wide reset assumed to also reset the slave).

## Timing
- Request accept at cycle 0 (req_valid_i & req_ready_o); AW/W or AR valid from cycle 1.
- Zero-wait slave (ready high, response next cycle after address): write: AW/W handshake cycle 1, B handshake cycle 2, resp_valid_o cycle 3. Read identical: AR cycle 1, R cycle 2, resp_valid_o cycle 3.
- Minimum request-to-request spacing: 4 cycles (next accept at cycle 4).
- Each added ready/valid wait cycle on any channel adds exactly one cycle to completion.
- AW and W skew: completion occurs one cycle after the later of the two handshakes.
- resp_rdata_o/resp_err_o update in the same cycle resp_valid_o rises and hold until the next DONE.

## Test plan
- Zero-wait write addr 0x2000_0010, wdata 0xDEAD_BEEF, sel 0xF, bresp 0 -> AW/W valid cycle 1 with those values, resp_valid_o pulse cycle 3, resp_err_o=0, resp_rdata_o=0.
- Read addr 0x0000_0004, slave rdata 0x1234_5678, arready delayed 3 cycles, rvalid 2 cycles after -> arvalid held 4 cycles with stable addr, resp_rdata_o=0x1234_5678, resp_valid_o one cycle.
- Write with awready at cycle 1, wready at cycle 5 (and reversed) -> awvalid drops after cycle 1, wvalid held until cycle 5, bready only from cycle 6, single resp_valid_o.
- Read with rresp=2'b10 and write with bresp=2'b11 -> resp_err_o=1 for each; subsequent OKAY read clears resp_err_o=0.
- req_valid_i held high continuously with alternating we -> req_ready_o high only in IDLE, exactly one AXI transaction per accepted request, no extra valids.
- Assert rst_n=0 while in WRESP with bvalid low -> bready, resp_valid_o, all valids 0 immediately; after release req_ready_o=1, next read completes normally.

Source files
------------

// File: rtl/jtag_axi_bridge.sv
// Debug-module memory port to AXI4-Lite master bridge.
// One request in flight at a time. AW and W are tracked independently so the
// slave may accept them in either order. The response is a single-cycle
// pulse; its data and error flag are held until the next completion.
module jtag_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // debug module request/response
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] sel;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q;
  logic              aw_pend_q, w_pend_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept, aw_hs, w_hs;

  // Only xRESP[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic              unused_resp_lsb;
  assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

  assign accept = req_valid_i & req_ready_o;
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;

  // Channel payloads come straight from the captured request, so they are
  // stable for as long as any valid is up.
  assign m_axi_awaddr = req_q.addr;
  assign m_axi_araddr = req_q.addr;
  assign m_axi_wdata  = req_q.wdata;
  assign m_axi_wstrb  = req_q.sel;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; every output is a decode of the state
  // so nothing depends combinationally on slave inputs.
  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    resp_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted even though the state reads IDLE.
        req_ready_o = rst_n;
        if (req_valid_i && rst_n) state_d = req_we_i ? WADDR : RADDR;
      end
      WADDR: begin
        m_axi_awvalid = aw_pend_q;
        m_axi_wvalid  = w_pend_q;
        if ((!aw_pend_q || m_axi_awready) && (!w_pend_q || m_axi_wready))
          state_d = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = DONE;
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = DONE;
      end
      DONE: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance; untouched while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      req_q <= '0;
    else if (accept) req_q <= '{addr: req_addr_i, wdata: req_wdata_i, sel: req_sel_i};
  end

  // Per-channel outstanding flags: both set on a write accept, each cleared
  // by its own handshake so AW and W can complete in any order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else if (accept && req_we_i) begin
      aw_pend_q <= 1'b1;
      w_pend_q  <= 1'b1;
    end else begin
      if (aw_hs) aw_pend_q <= 1'b0;
      if (w_hs)  w_pend_q  <= 1'b0;
    end
  end

  // Response data/error, loaded on the B or R handshake so they are valid in
  // the DONE cycle and held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == WRESP && m_axi_bvalid) begin
      rdata_q <= '0;
      err_q   <= m_axi_bresp[1];
    end else if (state_q == RDATA && m_axi_rvalid) begin
      rdata_q <= m_axi_rdata;
      err_q   <= m_axi_rresp[1];
    end
  end

endmodule

// File: tb/tb_jtag_axi_bridge.sv
// Self-checking bench for jtag_axi_bridge. A cycle-stepped AXI slave with
// per-transaction wait counts drives the bus; expected control timing comes
// from closed-form latency rules and expected data from a request-level
// memory model.
module tb_jtag_axi_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_sel;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int total = 0;
  int bad   = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  jtag_axi_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt(a);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = model_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    model_mem[a] = v;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return dflt(a);
  endfunction

  function automatic void slave_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = slave_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    slave_mem[a] = v;
  endfunction

  task automatic clear_slave();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  // One request from accept to the cycle after completion. Returns at the
  // falling edge where the bridge should be idle again.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] sel, input int aw_dly, input int w_dly,
                         input int b_dly, input int ar_dly, input int r_dly,
                         input logic [1:0] code, input bit hold);
    int tw, ta, td;
    int aw_hs, w_hs, ar_hs, b_sched, r_sched;
    bit b_done, r_done;
    logic [31:0] aw_a, w_d, r_val, exp_rdata;
    logic [3:0]  w_s;
    logic        exp_err;
    logic [6:0]  exp_v, obs_v;
    logic [105:0] exp_p, obs_p;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_sched = 0; r_sched = 0;
    b_done = 0; r_done = 0; aw_a = 0; w_d = 0; w_s = 0; r_val = 0;
    tw = 0; ta = 0;
    if (we) begin
      tw = 1 + ((aw_dly > w_dly) ? aw_dly : w_dly);
      td = tw + 2 + b_dly;
      exp_rdata = 32'h0;
      model_write(addr, wd, sel);
    end else begin
      ta = 1 + ar_dly;
      td = ta + 2 + r_dly;
      exp_rdata = model_read(addr);
    end
    exp_err = code[1];

    clear_slave();
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_sel = sel;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready addr=%h got=%b want=1", addr, req_ready);
    end
    @(posedge clk);
    for (int c = 1; c <= td + 1; c++) begin
      @(negedge clk);
      if (hold) begin
        req_valid = 1; req_we = ~req_we;
        req_addr = $urandom; req_wdata = $urandom; req_sel = 4'($urandom);
      end else req_valid = 0;
      awready = we && (c >= 1 + aw_dly);
      wready  = we && (c >= 1 + w_dly);
      arready = !we && (c >= 1 + ar_dly);
      bvalid  = (b_sched != 0) && (c >= b_sched) && !b_done;
      bresp   = code;
      rvalid  = (r_sched != 0) && (c >= r_sched) && !r_done;
      rresp   = code;
      rdata   = rvalid ? r_val : $urandom;

      exp_v = {c == td + 1,
               we && c <= 1 + aw_dly,
               we && c <= 1 + w_dly,
               we && c > tw && c < td,
               !we && c <= ta,
               !we && c > ta && c < td,
               c == td};
      obs_v = {req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid};
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL ctrl addr=%h cyc=%0d got=%b want=%b (rdy,aw,w,b,ar,r,resp)", addr, c, obs_v, exp_v);
      end

      if (awvalid || wvalid || arvalid) begin
        exp_p = {addr, 3'b000, wd, sel, addr, 3'b000};
        obs_p = {awaddr, awprot, wdata, wstrb, araddr, arprot};
        total++;
        if (obs_p !== exp_p) begin
          bad++; $display("FAIL payload cyc=%0d got=%h want=%h", c, obs_p, exp_p);
        end
      end

      if (awvalid && awready && aw_hs == 0) begin aw_hs = c; aw_a = awaddr; end
      if (wvalid && wready && w_hs == 0) begin w_hs = c; w_d = wdata; w_s = wstrb; end
      if (we && aw_hs != 0 && w_hs != 0 && b_sched == 0) begin
        b_sched = c + 1 + b_dly;
        slave_write(aw_a, w_d, w_s);
      end
      if (arvalid && arready && ar_hs == 0) begin
        ar_hs = c; r_sched = c + 1 + r_dly; r_val = slave_read(araddr);
      end
      if (bvalid && bready) b_done = 1;
      if (rvalid && rready) r_done = 1;

      if (c >= td) begin
        total++;
        if ({resp_rdata, resp_err} !== {exp_rdata, exp_err}) begin
          bad++; $display("FAIL resp addr=%h cyc=%0d got=%h/%b want=%h/%b", addr, c, resp_rdata, resp_err, exp_rdata, exp_err);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 0; clear_slave();
      total++;
      if ({req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid} !== 7'b1000000) begin
        bad++; $display("FAIL idle got=%b want=1000000", {req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_sel = 0;
    clear_slave();
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_rdata, resp_err} !== '0) begin
      bad++; $display("FAIL reset_outputs got rdy=%b resp=%b rdata=%h err=%b want all 0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst_n = 1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
    idle_cycles(2);
  endtask

  // B/R valids outside WRESP/RDATA must not be consumed.
  task automatic test_ignore_stray();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_slave(); bvalid = 1; rvalid = 1; rdata = 32'hFFFF_FFFF; bresp = 2'b10;
      total++;
      if ({bready, rready, resp_valid, req_ready} !== 4'b0001) begin
        bad++; $display("FAIL stray got=%b want=0001 (bready,rready,resp,rdy)", {bready, rready, resp_valid, req_ready});
      end
    end
    idle_cycles(1);
  endtask

  task automatic test_zero_wait_write();
    run_txn(1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(0, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic test_delayed_read();
    slave_mem[32'h4] = 32'h1234_5678;
    model_mem[32'h4] = 32'h1234_5678;
    run_txn(0, 32'h0000_0004, 0, 0, 0, 0, 0, 3, 1, 2'b00, 0);
  endtask

  task automatic test_skew();
    run_txn(1, 32'h3000_0000, 32'h0102_0304, 4'b0101, 0, 4, 0, 0, 0, 2'b00, 0);
    run_txn(1, 32'h3000_0000, 32'hAABB_CCDD, 4'b1010, 4, 0, 1, 0, 0, 2'b00, 0);
    run_txn(0, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic test_errors();
    run_txn(0, 32'h4000_0008, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0);
    run_txn(1, 32'h4000_000C, 32'h5555_AAAA, 4'hF, 1, 0, 2, 0, 0, 2'b11, 0);
    run_txn(0, 32'h4000_000C, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(0, 32'h4000_0010, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_txn(i[0], 32'h5000_0000 + 32'(4 * (i / 2)), $urandom, 4'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, 1);
    run_txn(0, 32'h5000_0000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
  endtask

  task automatic test_reset_mid_wresp();
    run_txn(0, 32'h0000_0004, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    clear_slave();
    req_valid = 1; req_we = 1; req_addr = 32'h6000_0000; req_wdata = 32'h1111_2222; req_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; awready = 1; wready = 1;
    @(posedge clk);
    @(negedge clk);
    awready = 0; wready = 0; bvalid = 0;
    total++;
    if (bready !== 1'b1) begin bad++; $display("FAIL mid_wresp_bready got=%b want=1", bready); end
    rst_n = 0;
    #1;
    total++;
    if ({req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_rdata, resp_err} !== '0) begin
      bad++; $display("FAIL mid_reset got rdy=%b bready=%b resp=%b rdata=%h err=%b want all 0",
                      req_ready, bready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b want=1", req_ready); end
    @(negedge clk);
    run_txn(0, 32'h0000_0004, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_ignore_stray();
    test_zero_wait_write();
    test_delayed_read();
    test_skew();
    test_errors();
    test_back_to_back();
    idle_cycles(2);
    test_random();
    test_reset_mid_wresp();
    idle_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
